// File: rtl/sm4_arb.sv
// sm4_arb: two-port round-robin front end for a shared SM4 engine.
// One transaction in flight; a watchdog aborts a stalled engine.
module sm4_arb #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [127:0] r0_data,
  input  logic [127:0] r0_key,
  input  logic         r0_dec,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [127:0] r1_data,
  input  logic [127:0] r1_key,
  input  logic         r1_dec,
  output logic         o0_valid,
  input  logic         o0_ready,
  output logic [127:0] o0_data,
  output logic         o0_err,
  output logic         o1_valid,
  input  logic         o1_ready,
  output logic [127:0] o1_data,
  output logic         o1_err,
  output logic         eng_start,
  output logic [127:0] eng_data,
  output logic [127:0] eng_key,
  output logic         eng_dec,
  input  logic [127:0] eng_dout,
  input  logic         eng_done,
  output logic         busy,
  output logic         grant_id
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]   state;
  logic [1:0]   state_nx;
  logic         last_grant;
  logic         gsel;
  logic         accept;
  logic         in_resp;
  logic         o_hs;
  logic         tmo;
  logic [7:0]   cnt;
  logic [127:0] resp_data;
  logic         resp_err;

  // On a tie the port that did not win last time is served.
  assign gsel     = (r0_valid & r1_valid) ? ~last_grant : r1_valid;
  assign accept   = (state == IDLE) & (r0_valid | r1_valid);
  assign r0_ready = accept & ~gsel;
  assign r1_ready = accept & gsel;

  assign eng_start = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign in_resp   = (state == RESP);
  assign tmo       = (cnt == 8'(TIMEOUT - 1));

  assign o0_valid = in_resp & ~grant_id;
  assign o1_valid = in_resp & grant_id;
  assign o0_data  = o0_valid ? resp_data : '0;
  assign o1_data  = o1_valid ? resp_data : '0;
  assign o0_err   = o0_valid & resp_err;
  assign o1_err   = o1_valid & resp_err;
  assign o_hs     = (o0_valid & o0_ready) | (o1_valid & o1_ready);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (eng_done || tmo) state_nx = RESP;
      RESP:    if (o_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) grant_id <= gsel;
      if (o_hs) last_grant <= grant_id;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eng_data <= '0;
      eng_key  <= '0;
      eng_dec  <= 1'b0;
    end else if (accept) begin
      eng_data <= gsel ? r1_data : r0_data;
      eng_key  <= gsel ? r1_key  : r0_key;
      eng_dec  <= gsel ? r1_dec  : r0_dec;
    end
  end

  // Done beats the watchdog when both land in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (state == ISSUE) cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 8'd1;
      if (state == WAIT) begin
        if (eng_done) begin
          resp_data <= eng_dout;
          resp_err  <= 1'b0;
        end else if (tmo) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sm4_arb.sv
// tb_sm4_arb: scoreboard bench for sm4_arb with a behavioural engine.
// Engine latency is programmable; 0 means it never signals done.
module tb_sm4_arb;

  localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] KB = 128'h00112233445566778899aabbccddeeff;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic r0_valid = 0, r1_valid = 0;
  logic r0_ready, r1_ready;
  logic [127:0] r0_data = '0, r1_data = '0, r0_key = '0, r1_key = '0;
  logic r0_dec = 0, r1_dec = 0;
  logic o0_valid, o1_valid;
  logic o0_ready = 0, o1_ready = 0;
  logic [127:0] o0_data, o1_data;
  logic o0_err, o1_err;
  logic eng_start;
  logic [127:0] eng_data, eng_key;
  logic eng_dec;
  logic [127:0] eng_dout = '0;
  logic eng_done;
  logic eng_done_m = 0;
  logic stray = 0;
  logic busy, grant_id;

  assign eng_done = eng_done_m | stray;

  sm4_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data),
    .r0_key(r0_key), .r0_dec(r0_dec),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data),
    .r1_key(r1_key), .r1_dec(r1_dec),
    .o0_valid(o0_valid), .o0_ready(o0_ready), .o0_data(o0_data),
    .o0_err(o0_err),
    .o1_valid(o1_valid), .o1_ready(o1_ready), .o1_data(o1_data),
    .o1_err(o1_err),
    .eng_start(eng_start), .eng_data(eng_data), .eng_key(eng_key),
    .eng_dec(eng_dec), .eng_dout(eng_dout), .eng_done(eng_done),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  function automatic logic [127:0] eng_model(input logic [127:0] d,
                                             input logic [127:0] k,
                                             input logic dec);
    if (!dec && d == PT && k == PT) return CT;
    if (dec && d == CT && k == PT) return PT;
    return d ^ {k[63:0], k[127:64]} ^ {128{dec}};
  endfunction

  // Engine: done exactly eng_lat cycles after the start cycle.
  int eng_lat = 33;
  int ecnt = 0;
  bit erun = 0;
  logic [127:0] eres = '0;
  always @(negedge clk) begin
    eng_done_m = 0;
    eng_dout = ~eres;
    if (erun) begin
      ecnt--;
      if (ecnt == 0) begin
        eng_done_m = 1;
        eng_dout = eres;
        erun = 0;
      end
    end
    if (eng_start) begin
      eres = eng_model(eng_data, eng_key, eng_dec);
      erun = (eng_lat > 0);
      ecnt = eng_lat;
    end
  end

  typedef struct {
    logic port;
    logic [127:0] data;
    logic err;
  } exp_t;
  exp_t sb[$];

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rstn) begin
      if (r0_valid && r0_ready) begin
        e.port = 0;
        e.err = (eng_lat == 0 || eng_lat > TO);
        e.data = e.err ? '0 : eng_model(r0_data, r0_key, r0_dec);
        sb.push_back(e);
      end
      if (r1_valid && r1_ready) begin
        e.port = 1;
        e.err = (eng_lat == 0 || eng_lat > TO);
        e.data = e.err ? '0 : eng_model(r1_data, r1_key, r1_dec);
        sb.push_back(e);
      end
      if (o0_valid && o0_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_p0 unexpected response data=%h", o0_data);
        end else begin
          e = sb.pop_front();
          if (e.port !== 1'b0 || o0_data !== e.data || o0_err !== e.err) begin
            failures++;
            $display("FAIL sb_p0 got p0 %h err=%b exp p%0d %h err=%b",
                     o0_data, o0_err, e.port, e.data, e.err);
          end
        end
      end
      if (o1_valid && o1_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_p1 unexpected response data=%h", o1_data);
        end else begin
          e = sb.pop_front();
          if (e.port !== 1'b1 || o1_data !== e.data || o1_err !== e.err) begin
            failures++;
            $display("FAIL sb_p1 got p1 %h err=%b exp p%0d %h err=%b",
                     o1_data, o1_err, e.port, e.data, e.err);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rstn = 0;
    r0_valid = 0;
    r1_valid = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    sb.delete();
  endtask

  task automatic test_reset();
    rstn = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({r0_ready, r1_ready, o0_valid, o1_valid, o0_err, o1_err,
         eng_start, busy, grant_id, eng_dec} !== 10'b0) begin
      failures++;
      $display("FAIL reset_ctl got %b exp 0",
               {r0_ready, r1_ready, o0_valid, o1_valid, o0_err, o1_err,
                eng_start, busy, grant_id, eng_dec});
    end
    checks++;
    if ({o0_data, o1_data, eng_data, eng_key} !== 512'b0) begin
      failures++;
      $display("FAIL reset_data got nonzero exp 0");
    end
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_enc_p0();
    int t, t_out, t_st, nst;
    bit o1_seen;
    logic [127:0] d;
    logic er;
    t_out = -1; t_st = -1; nst = 0; o1_seen = 0; d = '0; er = 1;
    eng_lat = 33; o0_ready = 1; o1_ready = 1;
    @(negedge clk);
    r0_valid = 1; r0_data = PT; r0_key = PT; r0_dec = 0;
    #1;
    t = cyc;
    checks++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      failures++;
      $display("FAIL enc_ready got %b%b exp 10", r0_ready, r1_ready);
    end
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      r0_valid = 0;
      #1;
      if (eng_start) begin nst++; t_st = cyc; end
      if (o1_valid) o1_seen = 1;
      if (o0_valid && t_out < 0) begin t_out = cyc; d = o0_data; er = o0_err; end
    end
    checks++;
    if (nst != 1 || t_st != t + 1) begin
      failures++;
      $display("FAIL enc_start got n=%0d at %0d exp 1 at %0d", nst, t_st, t + 1);
    end
    checks++;
    if (t_out != t + 35) begin
      failures++;
      $display("FAIL enc_lat got %0d exp %0d", t_out, t + 35);
    end
    checks++;
    if (d !== CT || er !== 1'b0) begin
      failures++;
      $display("FAIL enc_data got %h err=%b exp %h err=0", d, er, CT);
    end
    checks++;
    if (o1_seen) begin
      failures++;
      $display("FAIL enc_o1 got o1_valid=1 exp 0");
    end
  endtask

  task automatic test_dec_p1();
    int t, t_out;
    bit dec_bad, o0_seen;
    logic [127:0] d;
    t_out = -1; dec_bad = 0; o0_seen = 0; d = '0;
    eng_lat = 33;
    @(negedge clk);
    r1_valid = 1; r1_data = CT; r1_key = PT; r1_dec = 1;
    #1;
    t = cyc;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      r1_valid = 0;
      #1;
      if (busy && eng_dec !== 1'b1) dec_bad = 1;
      if (o0_valid) o0_seen = 1;
      if (o1_valid && t_out < 0) begin t_out = cyc; d = o1_data; end
    end
    checks++;
    if (t_out != t + 35 || d !== PT) begin
      failures++;
      $display("FAIL dec_p1 got %h at %0d exp %h at %0d", d, t_out, PT, t + 35);
    end
    checks++;
    if (dec_bad || o0_seen) begin
      failures++;
      $display("FAIL dec_mode got dec_bad=%b o0=%b exp 0 0", dec_bad, o0_seen);
    end
  endtask

  task automatic test_back_to_back();
    int n0, n1, k;
    bit bad, both;
    n0 = 0; n1 = 0; k = 0; bad = 0; both = 0;
    do_reset();
    eng_lat = 3; o0_ready = 1; o1_ready = 1;
    for (int i = 0; i < 150; i++) begin
      r0_valid = (n0 < 4); r0_data = 128'h1000 + 128'(n0);
      r0_key = KB; r0_dec = n0[0];
      r1_valid = (n1 < 4); r1_data = 128'h2000 + 128'(n1);
      r1_key = KB; r1_dec = 0;
      #1;
      if (r0_ready && r1_ready) both = 1;
      if (r0_valid && r0_ready) begin
        if (k % 2 != 0) bad = 1;
        k++; n0++;
      end else if (r1_valid && r1_ready) begin
        if (k % 2 != 1) bad = 1;
        k++; n1++;
      end
      @(negedge clk);
    end
    r0_valid = 0; r1_valid = 0;
    checks++;
    if (k != 8 || bad) begin
      failures++;
      $display("FAIL b2b_order got k=%0d bad=%b exp 8 0", k, bad);
    end
    checks++;
    if (both) begin
      failures++;
      $display("FAIL b2b_both_ready got 1 exp 0");
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_pending got %0d exp 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    bit stable, r0rdy, seen;
    stable = 1; r0rdy = 0; seen = 0;
    eng_lat = 5; o0_ready = 1; o1_ready = 0;
    @(negedge clk);
    r1_valid = 1; r1_data = 128'hbeef; r1_key = KB; r1_dec = 0;
    @(negedge clk);
    r1_valid = 0;
    r0_valid = 1; r0_data = 128'hcafe; r0_key = KB; r0_dec = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (o1_valid) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_resp got no o1_valid exp o1_valid");
    end
    held = o1_data;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (o1_data !== held || o1_valid !== 1'b1) stable = 0;
      if (r0_ready) r0rdy = 1;
    end
    checks++;
    if (!stable || r0rdy) begin
      failures++;
      $display("FAIL bp_hold got stable=%b r0_ready=%b exp 1 0", stable, r0rdy);
    end
    o1_ready = 1;
    @(negedge clk);
    #1;
    checks++;
    if (r0_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_next got r0_ready=%b busy=%b exp 1 0", r0_ready, busy);
    end
    @(negedge clk);
    r0_valid = 0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_timeout();
    int t, t_out;
    logic [127:0] d;
    logic er;
    for (int pass = 0; pass < 2; pass++) begin
      t_out = -1; d = '1; er = 0;
      eng_lat = (pass == 0) ? 0 : TO;
      o0_ready = 1;
      @(negedge clk);
      r0_valid = 1; r0_data = 128'h77 + 128'(pass); r0_key = KB; r0_dec = 0;
      #1;
      t = cyc;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        r0_valid = 0;
        #1;
        if (o0_valid && t_out < 0) begin t_out = cyc; d = o0_data; er = o0_err; end
      end
      checks++;
      if (t_out != t + TO + 2) begin
        failures++;
        $display("FAIL tmo_lat%0d got %0d exp %0d", pass, t_out, t + TO + 2);
      end
      checks++;
      if (pass == 0 && (er !== 1'b1 || d !== 128'b0)) begin
        failures++;
        $display("FAIL tmo_err got %h err=%b exp 0 err=1", d, er);
      end else if (pass == 1 &&
                   (er !== 1'b0 || d !== eng_model(128'h78, KB, 1'b0))) begin
        failures++;
        $display("FAIL tmo_tie got %h err=%b exp %h err=0",
                 d, er, eng_model(128'h78, KB, 1'b0));
      end
    end
    @(negedge clk);
    stray = 1;
    @(negedge clk);
    stray = 0;
    #1;
    checks++;
    if (busy || eng_start || o0_valid || o1_valid || eng_data !== 128'h78) begin
      failures++;
      $display("FAIL stray_done got busy=%b start=%b v=%b%b eng_data=%h exp idle",
               busy, eng_start, o0_valid, o1_valid, eng_data);
    end
  endtask

  task automatic test_reset_mid();
    bit leak;
    leak = 0;
    eng_lat = 20; o0_ready = 1; o1_ready = 1;
    @(negedge clk);
    r0_valid = 1; r0_data = 128'h55; r0_key = KB; r0_dec = 0;
    @(negedge clk);
    r0_valid = 0;
    repeat (8) @(negedge clk);
    rstn = 0;
    #1;
    checks++;
    if ({busy, eng_start, grant_id, eng_dec, o0_valid, o1_valid} !== 6'b0 ||
        {eng_data, eng_key, o0_data, o1_data} !== 512'b0) begin
      failures++;
      $display("FAIL rst_mid got busy=%b start=%b eng_data=%h exp 0",
               busy, eng_start, eng_data);
    end
    @(negedge clk);
    rstn = 1;
    sb.delete();
    repeat (25) begin
      @(negedge clk);
      #1;
      if (busy || o0_valid || o1_valid) leak = 1;
    end
    checks++;
    if (leak) begin
      failures++;
      $display("FAIL rst_late_done got activity exp idle");
    end
    r0_valid = 1; r0_data = 128'h66; r0_key = KB; r0_dec = 0;
    r1_valid = 1; r1_data = 128'h99; r1_key = KB; r1_dec = 1;
    eng_lat = 4;
    #1;
    checks++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_tie got %b%b exp 10", r0_ready, r1_ready);
    end
    @(negedge clk);
    r0_valid = 0; r1_valid = 0;
    repeat (15) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_pending got %0d exp 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_enc_p0();
    test_dec_p1();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
